// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the instruction-fetch sequencer: data width,
//   opcode constants (upper nibble of the first instruction byte), the FSM
//   state encoding and a small opcode classification helper.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_JMP = 4'hA;   // unconditional jump, operand = next byte
    localparam logic [3:0] OP_JZ  = 4'hB;   // jump if flag_z
    localparam logic [3:0] OP_JC  = 4'hC;   // jump if flag_c
    localparam logic [3:0] OP_HLT = 4'hF;   // halt until reset

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_FETCH_OP = 3'd3,
        S_BRANCH   = 3'd4,
        S_EXEC     = 3'd5,
        S_HALT     = 3'd6
    } state_e;

    // Two-byte opcodes: the sequencer fetches the target byte itself.
    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles every non-clock signal of the fetch sequencer.
//   master : the sequencer (drives memory request, PC controls, IR, status)
//   slave  : the surrounding system (memory, program counter, datapath)
//   Signals:
//     run        level, 1 = execute, 0 = stop at next instruction boundary
//     mem_data   program memory read data, valid with mem_ready
//     mem_ready  memory handshake completes this cycle
//     flag_z/c   datapath flags, sampled in BRANCH
//     exec_done  datapath finished the instruction in ir
//     mem_rd     read request, held until mem_ready
//     pc_enable  one-cycle PC increment pulse
//     ld / inp   one-cycle PC load pulse and load value
//     ir         instruction register
//     ir_valid   one-cycle pulse: new instruction in ir
//     halted     high in HALT
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic              run;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              flag_z;
    logic              flag_c;
    logic              exec_done;
    logic              mem_rd;
    logic              pc_enable;
    logic              ld;
    logic [DATA_W-1:0] inp;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              halted;

    modport master (
        input  run, mem_data, mem_ready, flag_z, flag_c, exec_done,
        output mem_rd, pc_enable, ld, inp, ir, ir_valid, halted
    );

    modport slave (
        output run, mem_data, mem_ready, flag_z, flag_c, exec_done,
        input  mem_rd, pc_enable, ld, inp, ir, ir_valid, halted
    );

endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch / control FSM. Fetches bytes at the current PC over a
//   req/ready handshake, latches them in IR, resolves two-byte jumps by
//   pulsing the program counter load, and hands all other opcodes to the
//   execute datapath. Every output is a register.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    fetch_sequencer_if.master (memory, PC control, IR, status)
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    fetch_sequencer_if.master         bus
);

    state_e            state_q;
    logic              mem_rd_q;
    logic              pc_en_q;
    logic              ld_q;
    logic [DATA_W-1:0] inp_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic              halted_q;
    logic [DATA_W-1:0] target_q;

    logic              branch_taken;

    assign branch_taken = (ir_q[7:4] == OP_JMP)
                        | ((ir_q[7:4] == OP_JZ) & bus.flag_z)
                        | ((ir_q[7:4] == OP_JC) & bus.flag_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mem_rd_q   <= 1'b0;
            pc_en_q    <= 1'b0;
            ld_q       <= 1'b0;
            inp_q      <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            target_q   <= '0;
        end else begin
            // Pulse outputs default low so each lasts exactly one cycle.
            pc_en_q    <= 1'b0;
            ld_q       <= 1'b0;
            ir_valid_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_q  <= S_FETCH;
                        mem_rd_q <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_q     <= bus.mem_data;
                        mem_rd_q <= 1'b0;
                        pc_en_q  <= 1'b1;
                        state_q  <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (ir_q[7:4] == OP_HLT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (is_jump(ir_q[7:4])) begin
                        state_q  <= S_FETCH_OP;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state_q    <= S_EXEC;
                        ir_valid_q <= 1'b1;
                    end
                end

                // Operand byte goes to the target register; IR keeps the opcode
                // so BRANCH can still decide on it.
                S_FETCH_OP: begin
                    if (bus.mem_ready) begin
                        target_q <= bus.mem_data;
                        mem_rd_q <= 1'b0;
                        pc_en_q  <= 1'b1;
                        state_q  <= S_BRANCH;
                    end
                end

                // The load pulse lands one cycle after the operand increment,
                // so pc_enable and ld never coincide.
                S_BRANCH: begin
                    if (branch_taken) begin
                        ld_q  <= 1'b1;
                        inp_q <= target_q;
                    end
                    if (bus.run) begin
                        state_q  <= S_FETCH;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_EXEC: begin
                    if (bus.exec_done) begin
                        if (bus.run) begin
                            state_q  <= S_FETCH;
                            mem_rd_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_HALT: begin
                    // Only reset leaves HALT.
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.pc_enable = pc_en_q;
    assign bus.ld        = ld_q;
    assign bus.inp       = inp_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer. The bench supplies a program
//   memory, an 8-bit program counter driven by the DUT's pc_enable/ld/inp,
//   and the datapath inputs. Directed steps cover reset, NOP fetch, wait
//   states, jumps, HLT, run drop and reset mid-operand; randomized programs
//   are checked against an instruction-level model of program flow.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_sequencer_if ifc();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0] prog [256];
    logic [7:0] env_pc;
    logic       ready_req;
    logic       rand_mode;
    logic       fz;
    logic       fc;

    int         checks = 0;
    int         errors = 0;
    int         pce_cnt, ld_cnt, irv_cnt, mrd_cnt;
    logic [7:0] last_inp;

    logic [7:0] mpc;   // model: address of the next instruction to complete
    int         ev;

    // Program counter of the surrounding system.
    always @(posedge clk or negedge reset) begin
        if (!reset)             env_pc <= 8'h00;
        else if (ifc.ld)        env_pc <= ifc.inp;
        else if (ifc.pc_enable) env_pc <= env_pc + 8'd1;
    end

    assign ifc.mem_data = prog[env_pc];
    assign ifc.flag_z   = fz;
    assign ifc.flag_c   = fc;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic op_is_jump(input logic [7:0] b);
        return (b[7:4] == OP_JMP) || (b[7:4] == OP_JZ) || (b[7:4] == OP_JC);
    endfunction

    function automatic logic op_taken(input logic [7:0] b);
        return (b[7:4] == OP_JMP) || ((b[7:4] == OP_JZ) && fz) || ((b[7:4] == OP_JC) && fc);
    endfunction

    // Skip over jumps that fall through: they leave no visible event.
    task automatic settle();
        int n = 0;
        while (op_is_jump(prog[mpc]) && !op_taken(prog[mpc]) && n < 130) begin
            mpc = mpc + 8'd2;
            n++;
        end
        chk("rnd_settle", {31'd0, n < 130}, 32'd1);
    endtask

    task automatic monitor();
        logic [7:0] nxt;
        logic [7:0] nxt2;
        if (ifc.pc_enable) pce_cnt++;
        if (ifc.ld)        begin ld_cnt++; last_inp = ifc.inp; end
        if (ifc.ir_valid)  irv_cnt++;
        if (ifc.mem_rd)    mrd_cnt++;
        chk("inv_pce_ld", {31'd0, ifc.pc_enable & ifc.ld}, 32'd0);
        chk("inv_halt_quiet", {31'd0, ifc.halted & (ifc.mem_rd | ifc.pc_enable | ifc.ld | ifc.ir_valid)}, 32'd0);
        if (rand_mode && ifc.ir_valid) begin
            settle();
            nxt = mpc + 8'd1;
            chk("rnd_ir", {24'd0, ifc.ir}, {24'd0, prog[mpc]});
            chk("rnd_nonjump", {31'd0, op_is_jump(prog[mpc])}, 32'd0);
            chk("rnd_pc_exec", {24'd0, env_pc}, {24'd0, nxt});
            mpc = nxt;
            ev++;
        end
        if (rand_mode && ifc.ld) begin
            settle();
            nxt  = mpc + 8'd1;
            nxt2 = mpc + 8'd2;
            chk("rnd_ld_taken", {31'd0, op_taken(prog[mpc])}, 32'd1);
            chk("rnd_inp", {24'd0, ifc.inp}, {24'd0, prog[nxt]});
            chk("rnd_pc_ld", {24'd0, env_pc}, {24'd0, nxt2});
            mpc = prog[nxt];
            ev++;
        end
    endtask

    // Memory never completes a read while the PC is being loaded.
    task automatic step();
        ifc.mem_ready = ready_req && !ifc.ld;
        @(posedge clk);
        #1;
        monitor();
        if (rand_mode) begin
            ready_req     = ($urandom_range(0, 3) != 0);
            ifc.exec_done = $urandom_range(0, 1) != 0;
        end
    endtask

    task automatic clear_counts();
        pce_cnt = 0; ld_cnt = 0; irv_cnt = 0; mrd_cnt = 0; last_inp = 8'h00;
    endtask

    task automatic do_reset();
        rand_mode     = 1'b0;
        ifc.run       = 1'b0;
        ready_req     = 1'b1;
        ifc.exec_done = 1'b1;
        fz = 1'b0; fc = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 8'h01;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        clear_counts();
    endtask

    task automatic jump_case(input logic [7:0] opb, input logic [7:0] tgt,
                             input logic z, input logic c, input logic exp_taken);
        logic [7:0] exp_pc;
        do_reset();
        fz = z; fc = c;
        prog[0] = opb; prog[1] = tgt;
        ifc.run = 1'b1;
        step(); step(); step();
        ifc.run = 1'b0;
        step(); step(); step();
        exp_pc = exp_taken ? tgt : 8'h02;
        chk("jmp_ld_count", ld_cnt, {31'd0, exp_taken});
        chk("jmp_inp", {24'd0, last_inp}, exp_taken ? {24'd0, tgt} : 32'd0);
        chk("jmp_pc", {24'd0, env_pc}, {24'd0, exp_pc});
        chk("jmp_pce_count", pce_cnt, 32'd2);
        chk("jmp_no_irvalid", irv_cnt, 32'd0);
        chk("jmp_mrd_count", mrd_cnt, 32'd2);
    endtask

    task automatic rand_phase(input logic z, input logic c);
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                prog[i] = {4'hA + 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            end else begin
                int n;
                n = $urandom_range(0, 11);
                prog[i] = {(n < 10) ? 4'(n) : 4'(n + 3), 4'($urandom_range(0, 15))};
            end
        end
        fz = z; fc = c;
        mpc = 8'h00; ev = 0;
        rand_mode = 1'b1;
        ifc.run = 1'b1;
        repeat (300) step();
        rand_mode = 1'b0;
        ifc.run = 1'b0;
        chk("rnd_progress", {31'd0, ev >= 10}, 32'd1);
    endtask

    initial begin
        rand_mode = 1'b0; ifc.run = 1'b0; ifc.exec_done = 1'b0; ifc.mem_ready = 1'b0;
        ready_req = 1'b1; fz = 1'b0; fc = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 8'h01;
        clear_counts();

        // Reset held while run toggles: everything stays zero.
        #1 reset = 1'b0;
        repeat (3) begin ifc.run = ~ifc.run; step(); end
        chk("rst_mem_rd", {31'd0, ifc.mem_rd}, 32'd0);
        chk("rst_pulses", {29'd0, ifc.pc_enable, ifc.ld, ifc.ir_valid}, 32'd0);
        chk("rst_halted", {31'd0, ifc.halted}, 32'd0);
        chk("rst_ir_inp", {16'd0, ifc.ir, ifc.inp}, 32'd0);
        reset = 1'b1; ifc.run = 1'b0; clear_counts();
        repeat (3) step();
        chk("idle_no_mem_rd", mrd_cnt, 32'd0);

        // NOP stream: 3 cycles per instruction, PC +1 each.
        do_reset();
        ifc.run = 1'b1;
        repeat (12) step();
        chk("nop_pce", pce_cnt, 32'd4);
        chk("nop_irvalid", irv_cnt, 32'd4);
        chk("nop_pc", {24'd0, env_pc}, 32'd4);
        chk("nop_ir", {24'd0, ifc.ir}, 32'h01);
        ifc.run = 1'b0;
        repeat (3) step();
        chk("nop_stop_idle", {31'd0, ifc.mem_rd}, 32'd0);

        // Wait states: three not-ready cycles.
        do_reset();
        ifc.run = 1'b1; ready_req = 1'b0;
        repeat (4) step();
        chk("wait_mrd_cycles", mrd_cnt, 32'd4);
        chk("wait_no_pce", pce_cnt, 32'd0);
        ready_req = 1'b1;
        step();
        chk("wait_pce", {31'd0, ifc.pc_enable}, 32'd1);
        chk("wait_mrd_drop", {31'd0, ifc.mem_rd}, 32'd0);

        // Jumps: JMP, JZ/JC taken and not taken, target 8'hFF.
        jump_case(8'hA0, 8'h18, 1'b0, 1'b0, 1'b1);
        jump_case(8'hB0, 8'h40, 1'b0, 1'b1, 1'b0);
        jump_case(8'hB0, 8'h40, 1'b1, 1'b0, 1'b1);
        jump_case(8'hC0, 8'h40, 1'b1, 1'b0, 1'b0);
        jump_case(8'hC5, 8'hFF, 1'b0, 1'b1, 1'b1);

        // HLT: permanent, quiet, run ignored.
        do_reset();
        prog[0] = 8'hF0;
        ifc.run = 1'b1;
        repeat (3) step();
        chk("hlt_halted", {31'd0, ifc.halted}, 32'd1);
        clear_counts();
        repeat (10) begin ifc.run = ~ifc.run; step(); end
        chk("hlt_stays", {31'd0, ifc.halted}, 32'd1);
        chk("hlt_no_mem_rd", mrd_cnt, 32'd0);
        chk("hlt_no_pce", pce_cnt, 32'd0);

        // run dropped mid-EXEC: finish the instruction, then IDLE.
        do_reset();
        ifc.exec_done = 1'b0; ifc.run = 1'b1;
        repeat (3) step();
        chk("exec_irvalid", {31'd0, ifc.ir_valid}, 32'd1);
        ifc.run = 1'b0;
        repeat (3) step();
        chk("exec_irvalid_once", irv_cnt, 32'd1);
        ifc.exec_done = 1'b1;
        repeat (4) step();
        chk("exec_stop_mrd", mrd_cnt, 32'd1);
        chk("exec_stop_idle", {31'd0, ifc.mem_rd}, 32'd0);

        // Reset asserted while waiting for the operand byte.
        do_reset();
        prog[0] = 8'hA0;
        ifc.run = 1'b1;
        step(); step();
        ready_req = 1'b0;
        step();
        chk("fop_mem_rd", {31'd0, ifc.mem_rd}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("fop_rst_mem_rd", {31'd0, ifc.mem_rd}, 32'd0);
        chk("fop_rst_ir", {24'd0, ifc.ir}, 32'd0);
        chk("fop_rst_pulses", {28'd0, ifc.pc_enable, ifc.ld, ifc.ir_valid, ifc.halted}, 32'd0);
        step();
        reset = 1'b1;
        ready_req = 1'b1;
        ifc.run = 1'b0;
        step();
        chk("fop_after_idle", {31'd0, ifc.mem_rd}, 32'd0);

        // Randomized programs under each flag combination.
        rand_phase(1'b0, 1'b0);
        rand_phase(1'b1, 1'b0);
        rand_phase(1'b0, 1'b1);
        rand_phase(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
